lsu_mem_arbiter: RTL and testbench
==================================

Name: lsu_mem_arbiter

Overview:
- Sequences load/store requests from NUM_REQ VLIW LSU slots onto the single data-memory port.
- Arbitrates round-robin and keeps one memory transaction outstanding.
- Generates byte enables and lane-aligned store data.
- Aligns, sign-extends or zero-extends load data, and emits a tagged register-file writeback.
- Sits between the slot decode stage and data memory; replaces per-slot writeback formatting.

Parameters:
- NUM_REQ, 2, number of LSU requester slots (1..4).
- RD_W, 5, register destination tag width.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  slot i has a request
- req_ready  output  NUM_REQ  slot i request accepted this cycle
- req_is_load  input  NUM_REQ  1 = load, 0 = store
- req_addr  input  NUM_REQ*32  byte address, slot i at [32i+31:32i]
- req_wdata  input  NUM_REQ*32  store data, low bits significant
- req_size  input  NUM_REQ*2  00 byte, 01 half, 10 word, 11 illegal
- req_zero_ext  input  NUM_REQ  unsigned load (LBU/LHU)
- req_rd  input  NUM_REQ*RD_W  load destination register
- mem_req_valid  output  1  memory request valid
- mem_req_ready  input  1  memory accepts request
- mem_we  output  1  1 = write
- mem_addr  output  32  word-aligned address (addr[1:0] forced to 00)
- mem_wdata  output  32  lane-replicated store data
- mem_be  output  4  byte enables
- mem_rsp_valid  input  1  load data valid, single-cycle pulse
- mem_rdata  input  32  load data word
- wb_valid  output  1  register write pulse
- wb_slot  output  $clog2(NUM_REQ) or 1  originating slot
- wb_rd  output  RD_W  destination register
- wb_data  output  32  formatted load result
- err  output  1  one-cycle pulse: illegal/misaligned request dropped

Behaviour:
- Reset (async, any state): FSM=IDLE, rr pointer=0; all outputs 0, including req_ready, mem_*, wb_*, err; captured request registers cleared.
- FSM IDLE:
  - Grant the first valid slot at or after rr pointer, scanning upward with wrap.
  - Pulse req_ready[grant] for that cycle.
  - Capture addr/size/zero_ext/rd/is_load/wdata/slot.
  - rr pointer <= grant+1 mod NUM_REQ.
  - Next state REQ, or ERR if the request is illegal.
- Illegal: size 11; zero_ext with size 10; half with addr[0]=1; word with addr[1:0]!=00.
- ERR: err=1 for one cycle; no memory access and no writeback; then IDLE.
- REQ:
  - mem_req_valid=1; mem_* held stable until mem_req_ready.
  - On a store handshake, go to IDLE; stores produce no writeback.
  - On a load handshake, go to WAIT.
- WAIT: on mem_rsp_valid, register formatted data.
  - Next cycle: wb_valid=1 for exactly one cycle with wb_slot/wb_rd/wb_data, and FSM returns to IDLE in that same cycle.
  - mem_rsp_valid outside WAIT is ignored.
- Latency: accept to mem_req_valid = 1 cycle. Load mem_rsp_valid to wb_valid = 1 cycle. Back-to-back accepts at most every 2 cycles (store with immediate ready).
- mem_be:
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1],1'b0}
  - word: 1111
- mem_wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load format: shifted = mem_rdata >> (8*addr[1:0]).
  - byte: zero_ext ? {24'b0, s[7:0]} : {{24{s[7]}}, s[7:0]}
  - half: same pattern with 16 bits
  - word: s
- Simultaneous requests: only the granted slot sees req_ready. Other slots hold valid and their request fields; no starvation, since each slot is served within NUM_REQ grants.
- req_ready is 0 in every state except IDLE.
- Reset mid-transaction: the in-flight transaction is abandoned with no writeback. A late mem_rsp_valid after reset arrives in IDLE and is ignored.

Test Plan:
- Slot0 LB, addr 0x103, mem_rdata 0x80AABBCC -> mem_addr 0x100, mem_be 1000, wb_data 0xFFFFFF80, wb_rd as given, wb_slot 0.
- Slot1 LHU, addr 0x202, mem_rdata 0xBEEF1234 -> mem_be 1100, wb_data 0x0000BEEF. The same request as LH gives 0xFFFFBEEF.
- Slot0 SB, addr 0x41, wdata 0x12345678, mem_req_ready held 0 for 3 cycles -> mem_* stable; mem_wdata 0x78787878; mem_be 0010; no wb_valid.
- Both slots valid continuously with 6 stores -> grants alternate 0,1,0,1,0,1 starting at 0.
- LW addr 0x6 -> err pulses 1 cycle, mem_req_valid stays 0, no wb_valid. LWU (size 10, zero_ext 1) at an aligned address -> same response.
- rst asserted in WAIT, then mem_rsp_valid pulsed after release -> all outputs 0 immediately on rst; no wb_valid; next request served normally starting with slot 0.

Source files
------------

// File: rtl/lsu_mem_arbiter.sv
// Round-robin load/store sequencer for NUM_REQ LSU slots onto one data-memory port.
// One transaction in flight; formats store lanes/byte enables and load writeback data.
module lsu_mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int RD_W    = 5,
  localparam int SLOT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_is_load,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  input  logic [NUM_REQ*2-1:0]    req_size,
  input  logic [NUM_REQ-1:0]      req_zero_ext,
  input  logic [NUM_REQ*RD_W-1:0] req_rd,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [3:0]              mem_be,
  input  logic                    mem_rsp_valid,
  input  logic [31:0]             mem_rdata,
  output logic                    wb_valid,
  output logic [SLOT_W-1:0]       wb_slot,
  output logic [RD_W-1:0]         wb_rd,
  output logic [31:0]             wb_data,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;

  state_t            state;
  logic [SLOT_W-1:0] rr_ptr;
  logic [SLOT_W-1:0] grant;
  logic              grant_vld;
  int                grant_idx;

  logic [1:0]        cap_off;
  logic [1:0]        cap_size;
  logic              cap_zext;
  logic [RD_W-1:0]   cap_rd;
  logic [SLOT_W-1:0] cap_slot;

  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [1:0]        sel_size;
  logic              sel_zext;
  logic              sel_load;
  logic [RD_W-1:0]   sel_rd;

  function automatic logic is_illegal(input logic [1:0] size, input logic zext,
                                      input logic [1:0] off);
    return (size == 2'b11) || (zext && size == 2'b10) ||
           (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [1:0] size,
                                           input logic zext, input logic [1:0] off);
    logic [31:0]        s;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    s  = rdata >> {off, 3'b000};
    sb = s[7:0];
    sh = s[15:0];
    case (size)
      2'b00:   return zext ? {24'b0, s[7:0]} : 32'(sb);
      2'b01:   return zext ? {16'b0, s[15:0]} : 32'(sh);
      default: return s;
    endcase
  endfunction

  // Lowest offset from rr_ptr wins; scan downward so the nearest slot is written last.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant     = SLOT_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign grant_idx = int'(grant);
  assign sel_addr  = req_addr[32*grant_idx +: 32];
  assign sel_wdata = req_wdata[32*grant_idx +: 32];
  assign sel_size  = req_size[2*grant_idx +: 2];
  assign sel_zext  = req_zero_ext[grant_idx];
  assign sel_load  = req_is_load[grant_idx];
  assign sel_rd    = req_rd[RD_W*grant_idx +: RD_W];

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == IDLE) && !rst && grant_vld && (grant == SLOT_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cap_off       <= '0;
      cap_size      <= '0;
      cap_zext      <= 1'b0;
      cap_rd        <= '0;
      cap_slot      <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      wb_valid      <= 1'b0;
      wb_slot       <= '0;
      wb_rd         <= '0;
      wb_data       <= '0;
      err           <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            rr_ptr   <= SLOT_W'((grant_idx + 1) % NUM_REQ);
            cap_off  <= sel_addr[1:0];
            cap_size <= sel_size;
            cap_zext <= sel_zext;
            cap_rd   <= sel_rd;
            cap_slot <= grant;
            if (is_illegal(sel_size, sel_zext, sel_addr[1:0])) begin
              err   <= 1'b1;
              state <= ERR;
            end else begin
              mem_req_valid <= 1'b1;
              mem_we        <= !sel_load;
              mem_addr      <= {sel_addr[31:2], 2'b00};
              mem_wdata     <= lane_data(sel_size, sel_wdata);
              mem_be        <= byte_en(sel_size, sel_addr[1:0]);
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= mem_we ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            wb_valid <= 1'b1;
            wb_slot  <= cap_slot;
            wb_rd    <= cap_rd;
            wb_data  <= fmt_load(mem_rdata, cap_size, cap_zext, cap_off);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: vector table plus scoreboard queues for memory
// requests, writebacks and error pulses; hand sequences for arbitration and reset.
module tb_lsu_mem_arbiter;
  localparam int NUM_REQ = 2;
  localparam int RD_W    = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      req_is_load;
  logic [NUM_REQ*32-1:0]   req_addr;
  logic [NUM_REQ*32-1:0]   req_wdata;
  logic [NUM_REQ*2-1:0]    req_size;
  logic [NUM_REQ-1:0]      req_zero_ext;
  logic [NUM_REQ*RD_W-1:0] req_rd;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_we;
  logic [31:0]             mem_addr;
  logic [31:0]             mem_wdata;
  logic [3:0]              mem_be;
  logic                    mem_rsp_valid;
  logic [31:0]             mem_rdata;
  logic                    wb_valid;
  logic [0:0]              wb_slot;
  logic [RD_W-1:0]         wb_rd;
  logic [31:0]             wb_data;
  logic                    err;

  lsu_mem_arbiter #(.NUM_REQ(NUM_REQ), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_load(req_is_load),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_zero_ext(req_zero_ext), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_slot(wb_slot), .wb_rd(wb_rd), .wb_data(wb_data),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              slot;
    logic            is_load;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [1:0]      size;
    logic            zext;
    logic [RD_W-1:0] rd;
    logic [31:0]     rdata;
    int              stall;
    logic            bad;
    logic [31:0]     exp_maddr;
    logic [3:0]      exp_be;
    logic [31:0]     exp_mwdata;
    logic [31:0]     exp_wb;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mexp_t;

  typedef struct {
    logic [0:0]      slot;
    logic [RD_W-1:0] rd;
    logic [31:0]     data;
  } wexp_t;

  mexp_t memq[$];
  wexp_t wbq[$];
  int    errq[$];
  int    n_pass = 0;
  int    n_total = 0;
  vec_t  vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input int slot, input logic ld, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic zext,
                              input logic [RD_W-1:0] rd, input logic [31:0] rdata, input int stall,
                              input logic bad, input logic [31:0] maddr, input logic [3:0] be,
                              input logic [31:0] mwdata, input logic [31:0] wb);
    vec_t v;
    v.slot = slot; v.is_load = ld; v.addr = addr; v.wdata = wdata; v.size = size;
    v.zext = zext; v.rd = rd; v.rdata = rdata; v.stall = stall; v.bad = bad;
    v.exp_maddr = maddr; v.exp_be = be; v.exp_mwdata = mwdata; v.exp_wb = wb;
    return v;
  endfunction

  function automatic logic [1:0] onehot(input int s);
    logic [1:0] o;
    o = '0;
    o[s] = 1'b1;
    return o;
  endfunction

  task automatic drive_slot(input int s, input logic ld, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size, input logic zext,
                            input logic [RD_W-1:0] rd);
    req_valid[s]          = 1'b1;
    req_is_load[s]        = ld;
    req_addr[32*s +: 32]  = addr;
    req_wdata[32*s +: 32] = wdata;
    req_size[2*s +: 2]    = size;
    req_zero_ext[s]       = zext;
    req_rd[RD_W*s +: RD_W] = rd;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_mem_req_valid"}, 32'(mem_req_valid), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_be"}, 32'(mem_be), 0);
    check({tag, "_wb"}, {wb_valid, wb_slot, 25'(wb_rd)}, 0);
    check({tag, "_wb_data"}, wb_data, 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  // Scoreboard: pop expected items as the DUT produces them.
  always @(negedge clk) begin : monitor
    mexp_t m;
    wexp_t w;
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        if (memq.size() == 0) check("mem_unexpected", 1, 0);
        else begin
          m = memq.pop_front();
          check("mem_we", 32'(mem_we), 32'(m.we));
          check("mem_addr", mem_addr, m.addr);
          check("mem_be", 32'(mem_be), 32'(m.be));
          if (m.we) check("mem_wdata", mem_wdata, m.wdata);
        end
      end
      if (wb_valid) begin
        if (wbq.size() == 0) check("wb_unexpected", 1, 0);
        else begin
          w = wbq.pop_front();
          check("wb_slot", 32'(wb_slot), 32'(w.slot));
          check("wb_rd", 32'(wb_rd), 32'(w.rd));
          check("wb_data", wb_data, w.data);
        end
      end
      if (err) begin
        if (errq.size() == 0) check("err_unexpected", 1, 0);
        else void'(errq.pop_front());
      end
    end
  end

  task automatic run_txn(input vec_t v, input int idx);
    int    n;
    mexp_t m;
    wexp_t w;
    string t;
    t = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    req_valid = '0;
    drive_slot(v.slot, v.is_load, v.addr, v.wdata, v.size, v.zext, v.rd);
    mem_req_ready = 1'b0;
    if (v.bad) errq.push_back(1);
    else begin
      m.we = !v.is_load; m.addr = v.exp_maddr; m.wdata = v.exp_mwdata; m.be = v.exp_be;
      memq.push_back(m);
      if (v.is_load) begin
        w.slot = 1'(v.slot); w.rd = v.rd; w.data = v.exp_wb;
        wbq.push_back(w);
      end
    end
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({t, "_accept"}, 32'(req_ready), 32'(onehot(v.slot)));
    @(posedge clk); #1;
    req_valid = '0;
    if (v.bad) begin
      @(negedge clk);
      check({t, "_err_pulse"}, 32'(err), 1);
      check({t, "_err_no_mem"}, 32'(mem_req_valid), 0);
      @(negedge clk);
      check({t, "_err_once"}, 32'(err), 0);
      check({t, "_err_no_mem2"}, 32'(mem_req_valid), 0);
      check({t, "_err_no_wb"}, 32'(wb_valid), 0);
    end else begin
      for (int s = 0; s < v.stall; s++) begin
        @(negedge clk);
        check({t, "_hold_valid"}, 32'(mem_req_valid), 1);
        check({t, "_hold_addr"}, mem_addr, v.exp_maddr);
        check({t, "_hold_be"}, 32'(mem_be), 32'(v.exp_be));
        check({t, "_hold_wdata"}, mem_wdata, v.exp_mwdata);
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      check({t, "_req_valid"}, 32'(mem_req_valid), 1);
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      if (v.is_load) begin
        mem_rsp_valid = 1'b1;
        mem_rdata     = v.rdata;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rdata     = $urandom;
        @(negedge clk);
        check({t, "_wb_latency"}, 32'(wb_valid), 1);
        @(negedge clk);
        check({t, "_wb_once"}, 32'(wb_valid), 0);
      end else begin
        @(negedge clk);
        check({t, "_store_no_wb"}, 32'(wb_valid), 0);
        check({t, "_store_done"}, 32'(mem_req_valid), 0);
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         g;
    int         n;
    int         wb_seen;
    logic [1:0] exp_g;
    int         rrq[$];
    mexp_t      m;

    vecs[0]  = mk(0, 1, 32'h103, 0, 2'b00, 0, 5'd5, 32'h80AABBCC, 0, 0, 32'h100, 4'b1000, 0, 32'hFFFFFF80);
    vecs[1]  = mk(1, 1, 32'h202, 0, 2'b01, 1, 5'd9, 32'hBEEF1234, 0, 0, 32'h200, 4'b1100, 0, 32'h0000BEEF);
    vecs[2]  = mk(1, 1, 32'h202, 0, 2'b01, 0, 5'd10, 32'hBEEF1234, 1, 0, 32'h200, 4'b1100, 0, 32'hFFFFBEEF);
    vecs[3]  = mk(0, 0, 32'h41, 32'h12345678, 2'b00, 0, 0, 0, 3, 0, 32'h40, 4'b0010, 32'h78787878, 0);
    vecs[4]  = mk(0, 1, 32'h6, 0, 2'b10, 0, 5'd4, 0, 0, 1, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 32'h8, 0, 2'b10, 1, 5'd4, 0, 0, 1, 0, 0, 0, 0);
    vecs[6]  = mk(0, 1, 32'h10, 0, 2'b10, 0, 5'd31, 32'hDEADBEEF, 2, 0, 32'h10, 4'b1111, 0, 32'hDEADBEEF);
    vecs[7]  = mk(1, 0, 32'h2, 32'hAAAA5555, 2'b01, 0, 0, 0, 0, 0, 32'h0, 4'b1100, 32'h55555555, 0);
    vecs[8]  = mk(0, 1, 32'h1, 0, 2'b00, 1, 5'd12, 32'h80AABBCC, 0, 0, 32'h0, 4'b0010, 0, 32'h000000BB);
    vecs[9]  = mk(0, 1, 32'h2, 0, 2'b00, 0, 5'd13, 32'h80AABBCC, 0, 0, 32'h0, 4'b0100, 0, 32'hFFFFFFAA);
    vecs[10] = mk(1, 0, 32'h1C, 32'hCAFEF00D, 2'b10, 0, 0, 0, 1, 0, 32'h1C, 4'b1111, 32'hCAFEF00D, 0);
    vecs[11] = mk(0, 1, 32'h1, 0, 2'b01, 0, 5'd2, 0, 0, 1, 0, 0, 0, 0);
    vecs[12] = mk(1, 0, 32'h0, 32'h1, 2'b11, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[13] = mk(0, 1, 32'h0, 0, 2'b01, 0, 5'd17, 32'h80AA7FFF, 0, 0, 32'h0, 4'b0011, 0, 32'h00007FFF);

    rst = 1'b1;
    req_valid = '1; req_is_load = '0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_zero_ext = '0; req_rd = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    req_valid = '0;
    mem_req_ready = 1'b0;
    rst = 1'b0;

    // Both slots hold stores continuously: grants must alternate from slot 0.
    rrq = {0, 1, 0, 1, 0, 1};
    for (int i = 0; i < 6; i++) begin
      m.we = 1'b1; m.be = 4'b1111;
      m.addr  = (i % 2 == 0) ? 32'h100 : 32'h200;
      m.wdata = (i % 2 == 0) ? 32'h11111111 : 32'h22222222;
      memq.push_back(m);
    end
    @(posedge clk); #1;
    drive_slot(0, 0, 32'h100, 32'h11111111, 2'b10, 0, 0);
    drive_slot(1, 0, 32'h200, 32'h22222222, 2'b10, 0, 0);
    mem_req_ready = 1'b1;
    g = 0; n = 0;
    while (g < 6 && n < 40) begin
      @(negedge clk);
      n++;
      if (req_ready != '0) begin
        exp_g = onehot(rrq.pop_front());
        check("rr_grant", 32'(req_ready), 32'(exp_g));
        g++;
      end
    end
    check("rr_grant_count", g, 6);
    check("rr_throughput", 32'(n <= 12), 1);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    mem_req_ready = 1'b0;

    for (int i = 0; i < 14; i++) run_txn(vecs[i], i);

    // Reset while waiting for load data; a late response must be ignored.
    @(posedge clk); #1;
    drive_slot(0, 1, 32'h300, 0, 2'b10, 0, 5'd7);
    m.we = 1'b0; m.addr = 32'h300; m.wdata = 0; m.be = 4'b1111;
    memq.push_back(m);
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rstw_accept", 32'(req_ready), 32'b01);
    @(posedge clk); #1;
    req_valid = '0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_zero_outputs("rst_wait");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    wb_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_valid) wb_seen++;
    end
    check("rst_late_rsp_no_wb", wb_seen, 0);

    m.we = 1'b1; m.addr = 32'h400; m.wdata = 32'hA5A5A5A5; m.be = 4'b1111;
    memq.push_back(m);
    @(posedge clk); #1;
    drive_slot(0, 0, 32'h400, 32'hA5A5A5A5, 2'b10, 0, 0);
    drive_slot(1, 0, 32'h500, 32'h5A5A5A5A, 2'b10, 0, 0);
    mem_req_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_first_grant", 32'(req_ready), 32'b01);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    @(negedge clk);

    check("memq_drained", memq.size(), 0);
    check("wbq_drained", wbq.size(), 0);
    check("errq_drained", errq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
